// File: rtl/pq_cmd_ctl.sv
// pq_cmd_ctl: push-button command front-end for a hardware priority queue.
// Three raw buttons are debounced; each debounced press leaves one pending
// request. An arbiter issues the requests one at a time to the PQ with
// busy/full/empty flow control. The block also shows the last dequeued pair,
// keeps an occupancy count and flags requests that had to be rejected.
module pq_cmd_ctl #(
    parameter int KW        = 8,
    parameter int VW        = 8,
    parameter int DEPTH     = 16,
    parameter int DB_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KW+VW-1:0]           sw_kv,
    input  logic                       btn_enq,
    input  logic                       btn_deq,
    input  logic                       btn_rep,
    input  logic                       pq_busy,
    input  logic                       pq_full,
    input  logic                       pq_empty,
    input  logic [KW+VW-1:0]           pq_kvo,
    output logic [KW+VW-1:0]           pq_kvi,
    output logic                       pq_enq,
    output logic                       pq_deq,
    output logic [KW+VW-1:0]           disp_kv,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       err_full,
    output logic                       err_empty,
    output logic                       ctl_busy
);

    localparam int W  = KW + VW;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int NB = 3;

    // Button slots; the slot index doubles as the request index.
    localparam int B_ENQ = 0;
    localparam int B_DEQ = 1;
    localparam int B_REP = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_ENQ = 2'd0,
        OP_DEQ = 2'd1,
        OP_REP = 2'd2
    } op_e;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] pend;       // one outstanding request per button
    logic [NB-1:0] pend_clr;   // arbiter consumes a request

    assign btn_raw = {btn_rep, btn_deq, btn_enq};

    // ------------------------------------------------------------------
    // Per-button debounce and pending-request latch
    // ------------------------------------------------------------------
    // The raw pins are assumed to be synchronous to clk already (or the
    // debounce window absorbs the rare metastable sample).
    for (genvar gi = 0; gi < NB; gi++) begin : g_btn
        logic [CW-1:0] cnt_q, cnt_d;
        logic          lvl_q, lvl_d;
        logic          prev_q;
        logic          pend_q, pend_d;

        // Count consecutive cycles where the pin disagrees with the level;
        // flip the level once the disagreement has lasted DB_CYCLES cycles.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (btn_raw[gi] != lvl_q) begin
                if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    lvl_d = ~lvl_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // A rising debounced level sets the request; a second press while
        // the request is still set merges into it and is thereby dropped.
        always_comb begin
            pend_d = (pend_q & ~pend_clr[gi]) | (lvl_q & ~prev_q);
        end

        // Debounce and request state registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
                prev_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
                prev_q <= lvl_q;
                pend_q <= pend_d;
            end
        end

        assign pend[gi] = pend_q;
    end

    // ------------------------------------------------------------------
    // Command FSM, arbitration, display capture and occupancy
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [W-1:0]   kv_q, kv_d;
    logic [W-1:0]   disp_q, disp_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic           err_full_q, err_full_d;
    logic           err_empty_q, err_empty_d;

    // Next-state logic: pick a request in IDLE, strobe in ISSUE, then
    // wait out the PQ's busy period before accepting the next request.
    always_comb begin
        op_e sel;
        state_d     = state_q;
        op_d        = op_q;
        kv_d        = kv_q;
        disp_d      = disp_q;
        occ_d       = occ_q;
        err_full_d  = err_full_q;
        err_empty_d = err_empty_q;
        pend_clr    = '0;
        sel         = OP_ENQ;

        case (state_q)
            ST_IDLE: begin
                if ((|pend) && !pq_busy) begin
                    // Replace outranks dequeue, which outranks enqueue.
                    if (pend[B_REP]) begin
                        sel = OP_REP;
                        pend_clr[B_REP] = 1'b1;
                    end else if (pend[B_DEQ]) begin
                        sel = OP_DEQ;
                        pend_clr[B_DEQ] = 1'b1;
                    end else begin
                        sel = OP_ENQ;
                        pend_clr[B_ENQ] = 1'b1;
                    end
                    op_d = sel;
                    kv_d = sw_kv;

                    if ((sel == OP_ENQ) && pq_full) begin
                        err_full_d  = 1'b1;
                        err_empty_d = 1'b0;
                    end else if ((sel != OP_ENQ) && pq_empty) begin
                        err_empty_d = 1'b1;
                        err_full_d  = 1'b0;
                    end else begin
                        err_full_d  = 1'b0;
                        err_empty_d = 1'b0;
                        state_d     = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                // The head is valid while the strobe is presented, so it is
                // captured now rather than after the PQ has moved on.
                if (op_q != OP_ENQ) begin
                    disp_d = pq_kvo;
                end
                // Counter saturates so a PQ that ignores full/empty cannot
                // make it wrap.
                if ((op_q == OP_ENQ) && (occ_q != OW'(DEPTH))) begin
                    occ_d = occ_q + OW'(1);
                end else if ((op_q == OP_DEQ) && (occ_q != '0)) begin
                    occ_d = occ_q - OW'(1);
                end
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Always at least one WAIT cycle, so busy may rise late.
                if (!pq_busy) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ENQ;
            kv_q        <= '0;
            disp_q      <= '0;
            occ_q       <= '0;
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            kv_q        <= kv_d;
            disp_q      <= disp_d;
            occ_q       <= occ_d;
            err_full_q  <= err_full_d;
            err_empty_q <= err_empty_d;
        end
    end

    // Strobes decode from registered state only, so they are glitch-free
    // and exactly one cycle long.
    assign pq_enq    = (state_q == ST_ISSUE) && (op_q != OP_DEQ);
    assign pq_deq    = (state_q == ST_ISSUE) && (op_q != OP_ENQ);
    assign pq_kvi    = kv_q;
    assign disp_kv   = disp_q;
    assign occ       = occ_q;
    assign err_full  = err_full_q;
    assign err_empty = err_empty_q;
    assign ctl_busy  = (state_q != ST_IDLE);

endmodule

// File: doc/pq_cmd_ctl.md
Name: pq_cmd_ctl

Overview:
- Parametrised board-level command front-end for the hardware priority queues.
- Debounces three push-buttons (enqueue, dequeue, replace) and turns each press into a single queued command.
- Issues each command to a priority-queue instance with busy/full/empty flow control, captures dequeued key/value pairs for display, tracks occupancy, and flags illegal requests.
- Sits between board pins and any PQ variant; 7-segment driving stays external.

Parameters:
- KW, 8, key field width in bits.
- VW, 8, value field width in bits.
- DEPTH, 16, queue capacity, used only for the occupancy count.
- DB_CYCLES, 16, consecutive stable cycles required before a debounced level changes (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- sw_kv  in  KW+VW  key/value from switches; key in the upper KW bits.
- btn_enq  in  1  raw enqueue button.
- btn_deq  in  1  raw dequeue button.
- btn_rep  in  1  raw replace (enq_deq) button.
- pq_busy  in  1  PQ busy.
- pq_full  in  1  PQ full.
- pq_empty  in  1  PQ empty.
- pq_kvo  in  KW+VW  PQ head key/value.
- pq_kvi  out  KW+VW  key/value to the PQ.
- pq_enq  out  1  one-cycle enqueue strobe.
- pq_deq  out  1  one-cycle dequeue strobe.
- disp_kv  out  KW+VW  last dequeued/replaced-out pair.
- occ  out  $clog2(DEPTH+1)  current entry count.
- err_full  out  1  sticky: last rejected request was enqueue-when-full.
- err_empty  out  1  sticky: last rejected request was deq/rep-when-empty.
- ctl_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: asserting rst (low) at any time, including mid-command, forces these values:
  - all outputs to 0;
  - debounce counters and debounced levels to 0;
  - pending bits cleared;
  - FSM to IDLE.
- Debounce: one counter per button.
  - If the raw input differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DB_CYCLES-1 while the input still differs, the debounced level toggles and the counter clears.
  - A 0->1 transition of the debounced level sets that button's pending bit on the next clock.
  - A press whose pending bit is already set is dropped.
- Arbitration in IDLE: when any pending bit is set and pq_busy=0, select by priority rep > deq > enq. Selection clears that pending bit and latches sw_kv into the command register.
  - enq with pq_full=1: reject, set err_full, clear err_empty, stay IDLE.
  - deq or rep with pq_empty=1: reject, set err_empty, clear err_full, stay IDLE.
  - otherwise: clear both error flags, go to ISSUE.
- FSM states:
  - IDLE.
  - ISSUE (exactly one cycle):
    - pq_kvi = latched value.
    - enq asserts pq_enq; deq asserts pq_deq; rep asserts both.
    - deq or rep captures pq_kvo into disp_kv at the end of this cycle.
    - Go to WAIT.
  - WAIT: leaves on the first cycle with pq_busy=0, returning to IDLE. WAIT lasts at least one cycle, so a PQ that raises busy one cycle late is tolerated.
- pq_kvi holds the latched value outside ISSUE; its value is don't-care when no strobe is asserted.
- Occupancy: updates at the end of ISSUE.
  - enq: +1.
  - deq: -1.
  - rep: unchanged.
  - Saturates at 0 and DEPTH; a PQ that violates full/empty does not wrap the counter.
- Latency: a debounced edge in cycle t sets pending at t+1. With the PQ idle, selection happens at t+1 and strobes at t+2.
- Throughput: at most one command per ISSUE/WAIT round trip (>=3 cycles per command). Presses arriving during ISSUE/WAIT are held pending, one per button.
- ctl_busy = (state != IDLE).

Test Plan:
- Reset: hold rst=0 with buttons toggling -> all outputs 0, no strobes. Release and hold btn_enq high for DB_CYCLES-1 cycles only -> no pq_enq.
- Enqueue: sw_kv=0x3A5C, btn_enq held high 40 cycles, pq_busy 0 -> exactly one pq_enq pulse with pq_kvi=0x3A5C; occ 0->1; err flags 0.
- Dequeue: PQ model head 0x1207, press btn_deq -> one pq_deq pulse; disp_kv=0x1207; occ decrements.
- Replace on full: occ=DEPTH, pq_full=1, head 0x0101, press btn_rep with sw_kv=0x7F00 -> pq_enq and pq_deq asserted together in one cycle; disp_kv=0x0101; occ unchanged at 16.
- Errors: pq_empty=1, press deq -> no strobe, err_empty=1. Then pq_full=1, press enq -> err_full=1, err_empty=0. Then a legal command clears both flags.
- Contention and reset:
  - Press enq, deq and rep within the same 2 cycles with pq_busy held high 10 cycles -> order on release is rep, then deq, then enq, each waiting for busy low.
  - Repeat and pull rst low during WAIT -> FSM IDLE, pending cleared, occ=0, no strobe after release.
